// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings,
// stall/flush bit positions and the divide timeout limit.
package pipe_ctrl_pkg;

    localparam int RADDR_WIDTH = 5;
    localparam int ADDR_WIDTH  = 32;

    // Bit positions within stall_o / flush_o
    localparam int IDX_PC      = 0;
    localparam int IDX_IF_ID   = 1;
    localparam int IDX_ID_EXE  = 2;
    localparam int IDX_EXE_MEM = 3;

    // Divide watchdog: give up after this many cycles without done
    localparam int DIV_TIMEOUT = 64;
    localparam int DIV_CNT_W   = $clog2(DIV_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check: the load in EXE writes a register
// that the instruction in ID is about to read. x0 never hazards.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                   is_load,
    input  logic                   reg_we,
    input  logic [RADDR_WIDTH-1:0] waddr,
    input  logic                   re1,
    input  logic [RADDR_WIDTH-1:0] raddr1,
    input  logic                   re2,
    input  logic [RADDR_WIDTH-1:0] raddr2,
    output logic                   load_use
);

    logic src1_hit;
    logic src2_hit;

    // Compare each enabled source address against the load destination
    always_comb begin
        src1_hit = re1 && (raddr1 == waddr);
        src2_hit = re2 && (raddr2 == waddr);
        load_use = is_load && reg_we && (waddr != '0) && (src1_hit || src2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / control FSM: jump flush, multi-cycle divide stall with
// timeout, debug halt and load-use interlock.
// Optional feature: define PIPE_CTRL_STALL_CNT_EN to build the saturating
// stall-cycle counter behind stall_cnt_o; otherwise that output is tied to 0.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_reg1_re_i,
    input  logic                   id_reg2_re_i,
    input  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i,
    input  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i,
    input  logic                   exe_is_load_i,
    input  logic                   exe_reg_we_i,
    input  logic [RADDR_WIDTH-1:0] exe_reg_waddr_i,
    input  logic                   exe_div_start_i,
    input  logic                   exe_div_done_i,
    input  logic                   exe_jump_i,
    input  logic [ADDR_WIDTH-1:0]  exe_jump_addr_i,
    input  logic                   halt_req_i,
    output logic [3:0]             stall_o,
    output logic [3:0]             flush_o,
    output logic                   redirect_o,
    output logic [ADDR_WIDTH-1:0]  redirect_addr_o,
    output logic                   div_timeout_o,
    output logic                   halted_o,
    output logic [31:0]            stall_cnt_o
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_TIMEOUT - 1);

    state_t               state_q;
    state_t               state_d;
    logic [DIV_CNT_W-1:0] div_cnt_q;
    logic                 load_use;

    hazard_detect u_hazard_detect (
        .is_load  (exe_is_load_i),
        .reg_we   (exe_reg_we_i),
        .waddr    (exe_reg_waddr_i),
        .re1      (id_reg1_re_i),
        .raddr1   (id_reg1_raddr_i),
        .re2      (id_reg2_re_i),
        .raddr2   (id_reg2_raddr_i),
        .load_use (load_use)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Divide watchdog: held at 0 outside DIV_WAIT, so entering DIV_WAIT starts from 0
    always_ff @(posedge clk_i) begin
        if (rst_i)                        div_cnt_q <= '0;
        else if (state_q == ST_DIV_WAIT)  div_cnt_q <= div_cnt_q + 1'b1;
        else                              div_cnt_q <= '0;
    end

    // Next state and combinational outputs; reset forces every output low
    always_comb begin
        state_d         = state_q;
        stall_o         = '0;
        flush_o         = '0;
        redirect_o      = 1'b0;
        redirect_addr_o = '0;
        div_timeout_o   = 1'b0;
        halted_o        = 1'b0;
        if (rst_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (exe_jump_i) begin
                        redirect_o             = 1'b1;
                        redirect_addr_o        = exe_jump_addr_i;
                        flush_o[IDX_IF_ID]     = 1'b1;
                        flush_o[IDX_ID_EXE]    = 1'b1;
                        state_d                = ST_FLUSH;
                    end else if (exe_div_start_i) begin
                        // done on the start cycle is deliberately not looked at
                        stall_o                = '1;
                        flush_o[IDX_EXE_MEM]   = 1'b1;
                        state_d                = ST_DIV_WAIT;
                    end else if (halt_req_i) begin
                        state_d                = ST_HALT;
                    end else if (load_use) begin
                        stall_o[IDX_PC]        = 1'b1;
                        stall_o[IDX_IF_ID]     = 1'b1;
                        flush_o[IDX_ID_EXE]    = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Second bubble for the wrong-path fetch; all events ignored
                    flush_o[IDX_IF_ID] = 1'b1;
                    state_d            = ST_RUN;
                end
                ST_DIV_WAIT: begin
                    if (exe_div_done_i) begin
                        state_d = ST_RUN;
                    end else if (div_cnt_q == DIV_LAST) begin
                        div_timeout_o = 1'b1;
                        state_d       = ST_RUN;
                    end else begin
                        stall_o              = '1;
                        flush_o[IDX_EXE_MEM] = 1'b1;
                    end
                end
                ST_HALT: begin
                    halted_o = 1'b1;
                    if (halt_req_i) begin
                        stall_o              = '1;
                        flush_o[IDX_EXE_MEM] = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles the PC is held, saturating at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i)                                     stall_cnt_q <= '0;
        else if (stall_o[IDX_PC] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 id_reg1_re_i, id_reg2_re_i  in  1 each  ID source-read enables.
REQ-005 id_reg1_raddr_i, id_reg2_raddr_i  in  RADDR_WIDTH (5) each  ID source addresses.
REQ-006 exe_is_load_i  in  1  EXE instruction is a load.
REQ-007 exe_reg_we_i  in  1  EXE write enable.
REQ-008 exe_reg_waddr_i  in  5  EXE destination.
REQ-009 exe_div_start_i  in  1  EXE begins a multi-cycle divide.
REQ-010 exe_div_done_i  in  1  divide result valid.
REQ-011 exe_jump_i  in  1  EXE resolved taken jump/branch.
REQ-012 exe_jump_addr_i  in  ADDR_WIDTH (32)  jump target.
REQ-013 halt_req_i  in  1  debug halt request, level.
REQ-014 stall_o  out  4  hold enables: [0] pc, [1] if_id, [2] id_exe, [3] exe_mem.
REQ-015 flush_o  out  4  bubble inserts: [1] if_id, [2] id_exe, [3] exe_mem; [0] always 0.
REQ-016 redirect_o  out  1  load pc from redirect_addr_o.
REQ-017 redirect_addr_o  out  32  new pc.
REQ-018 div_timeout_o  out  1  one-cycle pulse on divide timeout.
REQ-019 halted_o  out  1  high while in HALT.
REQ-020 stall_cnt_o  out  32  stall-cycle count (see Configuration).

Function
REQ-021 FSM states SHALL be RUN, FLUSH, DIV_WAIT and HALT; outputs are combinational from state and inputs; the next state is registered.
REQ-022 In RUN, events SHALL be evaluated in priority order: jump > div_start > halt_req > load-use.
REQ-023 On a RUN jump, the block SHALL assert redirect_o=1, redirect_addr_o=exe_jump_addr_i and flush_o=4'b0110, and the next state SHALL be FLUSH.
REQ-024 FLUSH SHALL last exactly 1 cycle with flush_o=4'b0010 and stall_o=0, then go to RUN; events arriving during FLUSH are ignored.
REQ-025 On a RUN div_start, the block SHALL assert stall_o=4'b1111 and flush_o=4'b1000 in the same cycle, and the next state SHALL be DIV_WAIT with the timeout counter cleared.
REQ-026 DIV_WAIT SHALL hold stall_o=4'b1111 and flush_o=4'b1000 while exe_div_done_i=0, incrementing a 6-bit counter each cycle.
REQ-027 When exe_div_done_i=1 in DIV_WAIT, the block SHALL drive stall_o=0 and flush_o=0 that cycle and return to RUN.
REQ-028 A done arriving on the same cycle as div_start SHALL be ignored.
REQ-029 When the counter reaches DIV_TIMEOUT-1 (63) without done, the block SHALL pulse div_timeout_o for 1 cycle, release the stalls and return to RUN.
REQ-030 halt_req_i SHALL be deferred while in DIV_WAIT or FLUSH.
REQ-031 On a RUN halt_req, the next state SHALL be HALT.
REQ-032 HALT SHALL hold stall_o=4'b1111, flush_o=4'b1000 and halted_o=1, and return to RUN in the first cycle halt_req_i=0, with no stall that cycle.
REQ-033 Load-use SHALL be detected in RUN when exe_is_load_i & exe_reg_we_i & (exe_reg_waddr_i!=0) & ((id_reg1_re_i & raddr1==waddr) | (id_reg2_re_i & raddr2==waddr)).
REQ-034 On load-use, the block SHALL assert stall_o=4'b0011 and flush_o=4'b0100 for that cycle only, with the state remaining RUN.
REQ-035 redirect_addr_o SHALL be 0 whenever redirect_o=0.

Reset
REQ-036 While rst_i=1, the next state SHALL be RUN, and the counter and stall_cnt_o SHALL clear to 0.
REQ-037 While rst_i=1, all outputs SHALL be 0 that cycle, overriding any state, including a reset taken mid-DIV_WAIT or mid-HALT.

Configuration
REQ-038 With PIPE_CTRL_STALL_CNT_EN defined, stall_cnt_o SHALL increment on each cycle with stall_o[0]=1 and saturate at 32'hFFFFFFFF.
REQ-039 Without PIPE_CTRL_STALL_CNT_EN, stall_cnt_o SHALL be tied to 0 and no counter register SHALL exist.

Structure
REQ-040 The shared defines file SHALL hold the state encodings, the stall/flush bit indices and DIV_TIMEOUT=64.
REQ-041 Load-use compare logic SHALL live in the sub-module hazard_detect (combinational), instantiated once.

Verification
REQ-042 Load x5 in EXE, ID reads rs1=x5 with re=1 -> one cycle of stall_o=0011, flush_o=0100; with rs1=x0 -> no stall.
REQ-043 Jump to 0x80000100 in RUN -> redirect_o=1 with that address, flush_o=0110, then 1 cycle flush_o=0010, then RUN.
REQ-044 div_start, then done after 10 cycles -> 11 cycles of stall_o=1111 including the start cycle; the 12th cycle has stall_o=0.
REQ-045 div_start with no done -> div_timeout_o pulses after 64 stalled cycles, then the stalls release.
REQ-046 halt_req raised during DIV_WAIT -> HALT is entered only after done; rst_i mid-HALT -> all outputs 0 and state RUN next cycle.
REQ-047 With PIPE_CTRL_STALL_CNT_EN defined, 5 load-use stalls plus 10 divide stall cycles -> stall_cnt_o=15.
